// File: rtl/pipeline_hazard_ctrl.sv
// =============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/bubble/flush sequencer for the 5-stage pipeline, with
//               saturating stall, bubble and flush performance counters.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_br_mispredict,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    output logic                 stall_n,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 nop_en,
    output logic                 br_flush,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] bubble_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_i_done;
    logic                 r_d_done;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_bubble_count;
    logic [CNT_WIDTH-1:0] r_flush_count;

    logic w_i_out;
    logic w_d_out;
    logic w_busy;
    logic w_lu;

    // A request is outstanding until its response has been seen in this stall episode
    assign w_i_out = imem_read & ~r_i_done;
    assign w_d_out = (dmem_read | dmem_write) & ~r_d_done;
    assign w_busy  = (w_i_out & ~imem_resp) | (w_d_out & ~dmem_resp);

    assign w_lu = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        stall_n    = 1'b0;
        pc_load    = 1'b0;
        if_id_load = 1'b0;
        nop_en     = 1'b0;
        br_flush   = 1'b0;
        if (!rst && !w_busy) begin
            stall_n = 1'b1;
            if (ex_br_mispredict) begin
                br_flush   = 1'b1;
                pc_load    = 1'b1;
                if_id_load = 1'b1;
            end else if (w_lu) begin
                nop_en = 1'b1;
            end else begin
                pc_load    = 1'b1;
                if_id_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_busy) begin
                        r_state  <= MEM_WAIT;
                        r_i_done <= w_i_out & imem_resp;
                        r_d_done <= w_d_out & dmem_resp;
                    end
                end
                MEM_WAIT: begin
                    if (w_busy) begin
                        r_i_done <= r_i_done | (w_i_out & imem_resp);
                        r_d_done <= r_d_done | (w_d_out & dmem_resp);
                    end else begin
                        r_state  <= RUN;
                        r_i_done <= 1'b0;
                        r_d_done <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!stall_n && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + c_one;
            if (nop_en && (r_bubble_count != '1))
                r_bubble_count <= r_bubble_count + c_one;
            if (br_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + c_one;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
    assign flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// =============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl (32-bit and 4-bit
//               counter instances driven in parallel).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       mis;
        logic       imem_read;
        logic       imem_resp;
        logic       dmem_read;
        logic       dmem_write;
        logic       dmem_resp;
    } stim_t;

    typedef struct packed {
        logic    stall_n;
        logic    pc_load;
        logic    if_id_load;
        logic    nop_en;
        logic    br_flush;
        longint  sc;
        longint  bc;
        longint  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_br_mispredict = 1'b0;
    logic        imem_read = 1'b0, imem_resp = 1'b0;
    logic        dmem_read = 1'b0, dmem_write = 1'b0, dmem_resp = 1'b0;

    logic        stall_n, pc_load, if_id_load, nop_en, br_flush;
    logic [31:0] stall_cycles, bubble_count, flush_count;
    logic        s_stall_n, s_pc_load, s_if_id_load, s_nop_en, s_br_flush;
    logic [3:0]  s_stall_cycles, s_bubble_count, s_flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_mispredict(ex_br_mispredict),
        .imem_read(imem_read), .imem_resp(imem_resp), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_resp(dmem_resp), .stall_n(stall_n),
        .pc_load(pc_load), .if_id_load(if_id_load), .nop_en(nop_en),
        .br_flush(br_flush), .stall_cycles(stall_cycles),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_mispredict(ex_br_mispredict),
        .imem_read(imem_read), .imem_resp(imem_resp), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_resp(dmem_resp), .stall_n(s_stall_n),
        .pc_load(s_pc_load), .if_id_load(s_if_id_load), .nop_en(s_nop_en),
        .br_flush(s_br_flush), .stall_cycles(s_stall_cycles),
        .bubble_count(s_bubble_count), .flush_count(s_flush_count)
    );

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    // Reference model: which caches have already answered during the current freeze
    logic   m_i_answered = 1'b0;
    logic   m_d_answered = 1'b0;
    longint m_sc = 0, m_bc = 0, m_fc = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 64'd15 : v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic do_cycle(input stim_t s);
        exp_t e;
        logic i_wait, d_wait, frozen, hazard;
        @(posedge clk);
        #1;
        rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read; ex_br_mispredict = s.mis;
        imem_read = s.imem_read; imem_resp = s.imem_resp; dmem_read = s.dmem_read;
        dmem_write = s.dmem_write; dmem_resp = s.dmem_resp;

        i_wait = s.imem_read && !m_i_answered;
        d_wait = (s.dmem_read || s.dmem_write) && !m_d_answered;
        frozen = (i_wait && !s.imem_resp) || (d_wait && !s.dmem_resp);
        hazard = s.ex_mem_read && (s.ex_rd != 0) &&
                 ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
        e = '0;
        if (!s.rst) begin
            e.stall_n    = !frozen;
            e.br_flush   = !frozen && s.mis;
            e.nop_en     = !frozen && !s.mis && hazard;
            e.pc_load    = !frozen && !e.nop_en;
            e.if_id_load = !frozen && !e.nop_en;
        end
        e.sc = m_sc; e.bc = m_bc; e.fc = m_fc;
        sb_q.push_back(e);

        if (s.rst) begin
            m_i_answered = 1'b0; m_d_answered = 1'b0;
            m_sc = 0; m_bc = 0; m_fc = 0;
        end else begin
            if (frozen) begin
                m_i_answered = m_i_answered || (i_wait && s.imem_resp);
                m_d_answered = m_d_answered || (d_wait && s.dmem_resp);
            end else begin
                m_i_answered = 1'b0; m_d_answered = 1'b0;
            end
            m_sc += frozen ? 1 : 0;
            m_bc += e.nop_en ? 1 : 0;
            m_fc += e.br_flush ? 1 : 0;
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall_n", longint'(stall_n), longint'(e.stall_n));
                chk("pc_load", longint'(pc_load), longint'(e.pc_load));
                chk("if_id_load", longint'(if_id_load), longint'(e.if_id_load));
                chk("nop_en", longint'(nop_en), longint'(e.nop_en));
                chk("br_flush", longint'(br_flush), longint'(e.br_flush));
                chk("stall_cycles", longint'(stall_cycles), e.sc);
                chk("bubble_count", longint'(bubble_count), e.bc);
                chk("flush_count", longint'(flush_count), e.fc);
                chk("small_stall_n", longint'(s_stall_n), longint'(e.stall_n));
                chk("small_stall_cycles", longint'(s_stall_cycles), sat4(e.sc));
                chk("small_bubble_count", longint'(s_bubble_count), sat4(e.bc));
                chk("small_flush_count", longint'(s_flush_count), sat4(e.fc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        repeat (2) @(posedge clk);

        s = idle(); s.rst = 1'b1; do_cycle(s);

        // Load-use bubble, then same pattern against x0
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1; do_cycle(s);
        s = idle(); do_cycle(s);
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 0; s.rs1 = 0; s.u1 = 1; do_cycle(s);
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 7; s.rs2 = 7; s.u2 = 1; do_cycle(s);

        // Split misses, both response orders
        for (int c = 0; c < 6; c++) begin
            s = idle(); s.imem_read = (c <= 2); s.dmem_read = (c <= 4);
            s.imem_resp = (c == 2); s.dmem_resp = (c == 4); do_cycle(s);
        end
        for (int c = 0; c < 6; c++) begin
            s = idle(); s.imem_read = (c <= 4); s.dmem_read = (c <= 2);
            s.imem_resp = (c == 4); s.dmem_resp = (c == 2); do_cycle(s);
        end
        // Simultaneous responses and an unrequested response
        s = idle(); s.imem_read = 1; s.dmem_write = 1; do_cycle(s);
        s = idle(); s.imem_read = 1; s.dmem_write = 1; s.imem_resp = 1; s.dmem_resp = 1; do_cycle(s);
        s = idle(); s.dmem_resp = 1; s.imem_resp = 1; do_cycle(s);

        // Mispredict beats load-use
        s = idle(); s.mis = 1; s.ex_mem_read = 1; s.ex_rd = 3; s.rs1 = 3; s.u1 = 1; do_cycle(s);

        // Mispredict held across a D-cache miss
        for (int c = 0; c < 5; c++) begin
            s = idle(); s.mis = (c <= 3); s.dmem_read = (c <= 3); s.dmem_resp = (c == 3); do_cycle(s);
        end

        // Reset in MEM_WAIT after the I-side already answered
        for (int c = 0; c < 8; c++) begin
            s = idle(); s.imem_read = (c <= 6); s.dmem_read = (c <= 2);
            s.imem_resp = (c == 1) || (c == 6); s.rst = (c == 2); do_cycle(s);
        end

        // Long miss for counter saturation in the 4-bit instance
        s = idle(); s.rst = 1; do_cycle(s);
        for (int c = 0; c < 24; c++) begin
            s = idle(); s.imem_read = (c < 20); s.imem_resp = (c == 19); do_cycle(s);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s.rst         = ($urandom_range(0, 99) < 2);
            s.rs1         = 5'($urandom_range(0, 3));
            s.rs2         = 5'($urandom_range(0, 3));
            s.u1          = 1'($urandom_range(0, 1));
            s.u2          = 1'($urandom_range(0, 1));
            s.ex_rd       = 5'($urandom_range(0, 3));
            s.ex_mem_read = ($urandom_range(0, 99) < 40);
            s.mis         = ($urandom_range(0, 99) < 15);
            s.imem_read   = ($urandom_range(0, 99) < 40);
            s.imem_resp   = ($urandom_range(0, 99) < 30);
            s.dmem_read   = ($urandom_range(0, 99) < 25);
            s.dmem_write  = ($urandom_range(0, 99) < 15);
            s.dmem_resp   = ($urandom_range(0, 99) < 30);
            do_cycle(s);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/bubble/flush sequencer for the 5-stage pipeline. It drives the per-stage load enables (stall_n) and the ID-stage nop_en and br_flush inputs, and gates PC and IF/ID loading. It resolves three hazard sources:
- I-cache and D-cache misses, which freeze the whole pipeline.
- Load-use data hazards, which insert one bubble in ID/EX.
- EX-resolved branch mispredicts, which flush IF/ID and ID/EX.
It also keeps saturating performance counters for stalls, bubbles and flushes.

Parameters:
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 index of the instruction in decode
id_rs2  in  5  rs2 index of the instruction in decode
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_br_mispredict  in  1  branch/jump in EX resolved against the prediction
imem_read  in  1  I-cache request active
imem_resp  in  1  I-cache response, 1-cycle pulse
dmem_read  in  1  D-cache read request active
dmem_write  in  1  D-cache write request active
dmem_resp  in  1  D-cache response, 1-cycle pulse
stall_n  out  1  global pipeline-register load enable
pc_load  out  1  PC register load enable
if_id_load  out  1  IF/ID register load enable
nop_en  out  1  replace the ID/EX control word with zero
br_flush  out  1  flush IF/ID and ID/EX
stall_cycles  out  CNT_WIDTH  cycles with stall_n=0
bubble_count  out  CNT_WIDTH  cycles with nop_en=1
flush_count  out  CNT_WIDTH  cycles with br_flush=1

Behaviour:
State: FSM {RUN, MEM_WAIT}; sticky flags i_done and d_done; three counters.

Reset (rst=1, synchronous):
- Next state is RUN; i_done=0, d_done=0; all counters 0.
- While rst=1, all 1-bit outputs are forced to 0.
- Reset has priority over every event, including mid-MEM_WAIT.

Outstanding requests:
- i_out = imem_read & ~i_done
- d_out = (dmem_read|dmem_write) & ~d_done
- busy = (i_out & ~imem_resp) | (d_out & ~dmem_resp)

RUN state:
- busy=1 → stall_n=0; go to MEM_WAIT.
- In that same cycle, set i_done if imem_resp; set d_done if dmem_resp.
- busy=0 → stall_n=1.

MEM_WAIT state:
- stall_n=0 while busy=1; responses keep setting i_done / d_done.
- First cycle with busy=0 (the last response arrives this cycle, or all requests already complete):
  - stall_n=1
  - clear i_done and d_done
  - go to RUN
- Zero-latency release: stall_n=1 in the final response cycle.
- Responses may arrive in either order or simultaneously.
- A resp with no matching request is ignored.

Load-use hazard:
- lu = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Applies only when stall_n=1 and ex_br_mispredict=0. Then:
  - nop_en=1, pc_load=0, if_id_load=0
  - other stages advance
- Exactly one bubble per hazard: the next cycle EX holds a nop, so lu deasserts.

Mispredict:
- When stall_n=1 and ex_br_mispredict=1:
  - br_flush=1, pc_load=1, if_id_load=1, nop_en=0
  - Mispredict has priority over lu.
- During a memory stall, br_flush is held 0. It asserts for exactly one cycle, in the release cycle (EX inputs are stable while stalled).

Default case (stall_n=1, no hazard):
- pc_load=1, if_id_load=1, nop_en=0, br_flush=0.

Stall case (stall_n=0):
- pc_load=0, if_id_load=0, nop_en=0, br_flush=0.

Counters:
- Each counter increments by 1 at the clock edge when its condition holds.
- Each saturates at all-ones; no wrap.
- Counters are not incremented while rst=1.

Outputs 1-bit are combinational from state and inputs; counters are registered.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, no memory requests → one cycle of nop_en=1, pc_load=0, if_id_load=0, stall_n=1; bubble_count=1. Repeat with ex_rd=0 → nop_en=0.
2. Split misses: imem_read and dmem_read rise at cycle 0; imem_resp at cycle 2, dmem_resp at cycle 4 → stall_n=0 for cycles 0–3, stall_n=1 at cycle 4; state RUN at cycle 5; stall_cycles=4. Repeat with responses in reverse order → same result.
3. Simultaneous mispredict and load-use (stall_n=1) → br_flush=1, nop_en=0, pc_load=1 for one cycle; flush_count=1, bubble_count=0.
4. ex_br_mispredict=1 held while a dmem miss resolves at cycle 3 → br_flush=0 for cycles 0–2, br_flush=1 only at cycle 3.
5. rst=1 at cycle 2 of MEM_WAIT with i_done=1 → next cycle state RUN, all counters 0; still-asserted imem_read is treated as outstanding again (stall_n=0 until a new imem_resp).
6. CNT_WIDTH=4, hold a miss for 20 cycles → stall_cycles saturates at 15 and stays at 15.
